// File: rtl/uc_pkg.sv
// Shared definitions for the uc_mc multicycle control unit: opcodes, state encoding,
// ALU operation classes and writeback select codes.
package uc_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_NOP    = 7'b0000000;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    CLS_R, CLS_I, CLS_LOAD, CLS_STORE, CLS_BRANCH,
    CLS_JAL, CLS_JALR, CLS_LUI, CLS_NOP, CLS_ILLEGAL
  } op_class_t;

  localparam logic [3:0] ALUOP_ADD    = 4'b0000;
  localparam logic [3:0] ALUOP_BRANCH = 4'b0001;
  localparam logic [3:0] ALUOP_LUI    = 4'b0010;
  localparam logic [3:0] ALUOP_R      = 4'b0110;
  localparam logic [3:0] ALUOP_I      = 4'b0111;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MEM = 2'b01;
  localparam logic [1:0] M2R_PC4 = 2'b10;

endpackage

// File: rtl/uc_mc_decode.sv
// Combinational decode of the latched opcode into its class and the
// state-independent datapath controls (aluop, luisrc, alusrc, memtoreg).
module uc_mc_decode
  import uc_pkg::*;
#(
  parameter int ALUOP_W = 4
) (
  input  logic [6:0]         op_q,
  output logic [ALUOP_W-1:0] aluop,
  output logic               luisrc,
  output logic               alusrc,
  output logic [1:0]         memtoreg,
  output logic [3:0]         op_class
);

  op_class_t  cls;
  logic [3:0] aluop_code;

  // Nop shares the I-ALU encoding so it behaves as addi x0,x0,0.
  always_comb begin
    cls        = CLS_ILLEGAL;
    aluop_code = ALUOP_ADD;
    luisrc     = 1'b0;
    alusrc     = 1'b0;
    memtoreg   = M2R_ALU;
    case (op_q)
      OP_R:      begin cls = CLS_R;      aluop_code = ALUOP_R; end
      OP_I:      begin cls = CLS_I;      aluop_code = ALUOP_I; alusrc = 1'b1; end
      OP_NOP:    begin cls = CLS_NOP;    aluop_code = ALUOP_I; alusrc = 1'b1; end
      OP_LOAD:   begin cls = CLS_LOAD;   alusrc = 1'b1; memtoreg = M2R_MEM; end
      OP_STORE:  begin cls = CLS_STORE;  alusrc = 1'b1; end
      OP_BRANCH: begin cls = CLS_BRANCH; aluop_code = ALUOP_BRANCH; end
      OP_JAL:    begin cls = CLS_JAL;    memtoreg = M2R_PC4; end
      OP_JALR:   begin cls = CLS_JALR;   alusrc = 1'b1; memtoreg = M2R_PC4; end
      OP_LUI:    begin cls = CLS_LUI;    aluop_code = ALUOP_LUI; luisrc = 1'b1; end
      default:   cls = CLS_ILLEGAL;
    endcase
  end

  assign aluop    = ALUOP_W'(aluop_code);
  assign op_class = cls;

endmodule

// File: rtl/uc_mc.sv
// Multicycle control unit FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP) with memory wait timeout.
// Optional performance counters are enabled by defining UC_MC_PERF_EN.
module uc_mc
  import uc_pkg::*;
#(
  parameter int ALUOP_W = 4,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         opcode,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               irwrite,
  output logic               pcwrite,
  output logic               regwrite,
  output logic               luisrc,
  output logic               alusrc,
  output logic               memwrite,
  output logic               memread,
  output logic               jumppc,
  output logic               jumpcontrol,
  output logic               bne,
  output logic [ALUOP_W-1:0] aluop,
  output logic [1:0]         memtoreg,
  output logic [2:0]         state,
  output logic               err
`ifdef UC_MC_PERF_EN
  ,
  output logic [31:0]        cycle_cnt,
  output logic [31:0]        instr_cnt
`endif
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  state_t             state_q, state_d;
  logic [6:0]         op_q;
  logic [WAIT_W-1:0]  wait_cnt;
  logic               timeout_hit;
  logic [ALUOP_W-1:0] dec_aluop;
  logic               dec_luisrc, dec_alusrc;
  logic [1:0]         dec_memtoreg;
  logic [3:0]         dec_class_bits;
  op_class_t          op_class;

  uc_mc_decode #(.ALUOP_W(ALUOP_W)) u_decode (
    .op_q     (op_q),
    .aluop    (dec_aluop),
    .luisrc   (dec_luisrc),
    .alusrc   (dec_alusrc),
    .memtoreg (dec_memtoreg),
    .op_class (dec_class_bits)
  );

  assign op_class = op_class_t'(dec_class_bits);
  assign state    = state_q;

  // The access traps on the cycle that would bring the wait count up to TIMEOUT.
  assign timeout_hit = !mem_ready && (wait_cnt == WAIT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_FETCH;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                         op_q <= 7'b0000000;
    else if (state_q == ST_FETCH && mem_ready)       op_q <= opcode;
  end

  // Held at zero outside FETCH/MEM so every entry into those states starts a fresh count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                                     wait_cnt <= '0;
    else if ((state_q == ST_FETCH || state_q == ST_MEM) && !mem_ready) wait_cnt <= wait_cnt + 1'b1;
    else                                                         wait_cnt <= '0;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: begin
        if (mem_ready)        state_d = ST_DECODE;
        else if (timeout_hit) state_d = ST_TRAP;
      end
      ST_DECODE: state_d = (op_class == CLS_ILLEGAL) ? ST_TRAP : ST_EXEC;
      ST_EXEC: begin
        case (op_class)
          CLS_LOAD, CLS_STORE: state_d = ST_MEM;
          CLS_BRANCH:          state_d = ST_FETCH;
          default:             state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (mem_ready)        state_d = (op_class == CLS_LOAD) ? ST_WB : ST_FETCH;
        else if (timeout_hit) state_d = ST_TRAP;
      end
      ST_WB:   state_d = ST_FETCH;
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_FETCH;
    endcase
  end

  always_comb begin
    mem_req     = 1'b0;
    irwrite     = 1'b0;
    pcwrite     = 1'b0;
    regwrite    = 1'b0;
    luisrc      = 1'b0;
    alusrc      = 1'b0;
    memwrite    = 1'b0;
    memread     = 1'b0;
    jumppc      = 1'b0;
    jumpcontrol = 1'b0;
    bne         = 1'b0;
    aluop       = '0;
    memtoreg    = M2R_ALU;
    err         = 1'b0;
    // Decoded ALU controls are only driven once the instruction is past DECODE.
    if (state_q == ST_EXEC || state_q == ST_MEM || state_q == ST_WB) begin
      aluop  = dec_aluop;
      luisrc = dec_luisrc;
      alusrc = dec_alusrc;
    end
    case (state_q)
      ST_FETCH: begin
        mem_req = 1'b1;
        memread = 1'b1;
        irwrite = mem_ready;
        pcwrite = mem_ready;
      end
      ST_EXEC: begin
        if (op_class == CLS_BRANCH) begin
          bne         = 1'b1;
          jumpcontrol = 1'b1;
        end
        if (op_class == CLS_JAL || op_class == CLS_JALR) jumppc = 1'b1;
      end
      ST_MEM: begin
        mem_req  = 1'b1;
        memread  = (op_class == CLS_LOAD);
        memwrite = (op_class == CLS_STORE);
      end
      ST_WB: begin
        regwrite = 1'b1;
        memtoreg = dec_memtoreg;
      end
      ST_TRAP: err = 1'b1;
      default: ;
    endcase
  end

`ifdef UC_MC_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt <= 32'd0;
      instr_cnt <= 32'd0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (state_d == ST_FETCH &&
          (state_q == ST_WB || state_q == ST_EXEC || state_q == ST_MEM))
        instr_cnt <= instr_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_uc_mc.sv
// Self-checking bench for uc_mc: a per-cycle vector table walking every opcode class,
// plus directed sequences for reset, timeouts, traps and (with UC_MC_PERF_EN) counters.
module tb_uc_mc;

  localparam logic [6:0] R    = 7'b0110011;
  localparam logic [6:0] IALU = 7'b0010011;
  localparam logic [6:0] LD   = 7'b0000011;
  localparam logic [6:0] ST   = 7'b0100011;
  localparam logic [6:0] BR   = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;
  localparam logic [6:0] LUI  = 7'b0110111;
  localparam logic [6:0] NOP  = 7'b0000000;
  localparam logic [6:0] BAD  = 7'b1111111;

  localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2, S_M = 3'd3, S_W = 3'd4, S_T = 3'd5;

  // ctrl order: mem_req irwrite pcwrite regwrite | luisrc alusrc memwrite memread | jumppc jumpcontrol bne err
  localparam logic [11:0] C_FETCH = 12'b1110_0001_0000;
  localparam logic [11:0] C_FWAIT = 12'b1000_0001_0000;
  localparam logic [11:0] C_NONE  = 12'b0000_0000_0000;
  localparam logic [11:0] C_TRAP  = 12'b0000_0000_0001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  opcode = '0;
  logic        mem_ready = 1'b0;
  logic        mem_req, irwrite, pcwrite, regwrite, luisrc, alusrc, memwrite, memread;
  logic        jumppc, jumpcontrol, bne, err;
  logic [3:0]  aluop;
  logic [1:0]  memtoreg;
  logic [2:0]  state;
  logic [11:0] ctrl_act;
`ifdef UC_MC_PERF_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uc_mc #(.ALUOP_W(4), .TIMEOUT(15)) dut (
    .clk         (clk),
    .rst         (rst),
    .opcode      (opcode),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .irwrite     (irwrite),
    .pcwrite     (pcwrite),
    .regwrite    (regwrite),
    .luisrc      (luisrc),
    .alusrc      (alusrc),
    .memwrite    (memwrite),
    .memread     (memread),
    .jumppc      (jumppc),
    .jumpcontrol (jumpcontrol),
    .bne         (bne),
    .aluop       (aluop),
    .memtoreg    (memtoreg),
    .state       (state),
    .err         (err)
`ifdef UC_MC_PERF_EN
    ,
    .cycle_cnt   (cycle_cnt),
    .instr_cnt   (instr_cnt)
`endif
  );

  assign ctrl_act = {mem_req, irwrite, pcwrite, regwrite, luisrc, alusrc,
                     memwrite, memread, jumppc, jumpcontrol, bne, err};

  typedef struct {
    logic [6:0]  opcode;
    logic        mem_ready;
    logic [2:0]  state;
    logic [11:0] ctrl;
    logic [3:0]  aluop;
    logic [1:0]  memtoreg;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input logic [6:0] op, input logic rdy, input logic [2:0] st,
                        input logic [11:0] c, input logic [3:0] alu, input logic [1:0] m2r);
    vec_t v;
    v.opcode = op; v.mem_ready = rdy; v.state = st; v.ctrl = c; v.aluop = alu; v.memtoreg = m2r;
    vecs.push_back(v);
  endtask

  // Called right after a falling edge; drives inputs and lets combinational outputs settle.
  task automatic applyStimulus(input logic [6:0] op, input logic rdy);
    opcode    = op;
    mem_ready = rdy;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic resetDut();
    rst = 1'b1;
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic stepIdle(input logic [6:0] op, input logic rdy, input int n);
    for (int k = 0; k < n; k++) begin
      applyStimulus(op, rdy);
      @(negedge clk);
    end
  endtask

  initial begin
    // R-type, with one FETCH wait cycle first
    addVec(R,    0, S_F, C_FWAIT, 4'b0000, 2'b00);
    addVec(R,    1, S_F, C_FETCH, 4'b0000, 2'b00);
    addVec(R,    1, S_D, C_NONE,  4'b0000, 2'b00);
    addVec(R,    1, S_E, C_NONE,  4'b0110, 2'b00);
    addVec(R,    1, S_W, 12'b0001_0000_0000, 4'b0110, 2'b00);
    // I-ALU
    addVec(IALU, 1, S_F, C_FETCH, 4'b0000, 2'b00);
    addVec(IALU, 1, S_D, C_NONE,  4'b0000, 2'b00);
    addVec(IALU, 1, S_E, 12'b0000_0100_0000, 4'b0111, 2'b00);
    addVec(IALU, 1, S_W, 12'b0001_0100_0000, 4'b0111, 2'b00);
    // load with three MEM wait cycles: 8 cycles total
    addVec(LD,   1, S_F, C_FETCH, 4'b0000, 2'b00);
    addVec(LD,   1, S_D, C_NONE,  4'b0000, 2'b00);
    addVec(LD,   1, S_E, 12'b0000_0100_0000, 4'b0000, 2'b00);
    addVec(LD,   0, S_M, 12'b1000_0101_0000, 4'b0000, 2'b00);
    addVec(LD,   0, S_M, 12'b1000_0101_0000, 4'b0000, 2'b00);
    addVec(LD,   0, S_M, 12'b1000_0101_0000, 4'b0000, 2'b00);
    addVec(LD,   1, S_M, 12'b1000_0101_0000, 4'b0000, 2'b00);
    addVec(LD,   1, S_W, 12'b0001_0100_0000, 4'b0000, 2'b01);
    // store
    addVec(ST,   1, S_F, C_FETCH, 4'b0000, 2'b00);
    addVec(ST,   1, S_D, C_NONE,  4'b0000, 2'b00);
    addVec(ST,   1, S_E, 12'b0000_0100_0000, 4'b0000, 2'b00);
    addVec(ST,   1, S_M, 12'b1000_0110_0000, 4'b0000, 2'b00);
    // branch: 3 cycles
    addVec(BR,   1, S_F, C_FETCH, 4'b0000, 2'b00);
    addVec(BR,   1, S_D, C_NONE,  4'b0000, 2'b00);
    addVec(BR,   1, S_E, 12'b0000_0000_0110, 4'b0001, 2'b00);
    // jal
    addVec(JAL,  1, S_F, C_FETCH, 4'b0000, 2'b00);
    addVec(JAL,  1, S_D, C_NONE,  4'b0000, 2'b00);
    addVec(JAL,  1, S_E, 12'b0000_0000_1000, 4'b0000, 2'b00);
    addVec(JAL,  1, S_W, 12'b0001_0000_0000, 4'b0000, 2'b10);
    // jalr
    addVec(JALR, 1, S_F, C_FETCH, 4'b0000, 2'b00);
    addVec(JALR, 1, S_D, C_NONE,  4'b0000, 2'b00);
    addVec(JALR, 1, S_E, 12'b0000_0100_1000, 4'b0000, 2'b00);
    addVec(JALR, 1, S_W, 12'b0001_0100_0000, 4'b0000, 2'b10);
    // lui
    addVec(LUI,  1, S_F, C_FETCH, 4'b0000, 2'b00);
    addVec(LUI,  1, S_D, C_NONE,  4'b0000, 2'b00);
    addVec(LUI,  1, S_E, 12'b0000_1000_0000, 4'b0010, 2'b00);
    addVec(LUI,  1, S_W, 12'b0001_1000_0000, 4'b0010, 2'b00);
    // nop
    addVec(NOP,  1, S_F, C_FETCH, 4'b0000, 2'b00);
    addVec(NOP,  1, S_D, C_NONE,  4'b0000, 2'b00);
    addVec(NOP,  1, S_E, 12'b0000_0100_0000, 4'b0111, 2'b00);
    addVec(NOP,  1, S_W, 12'b0001_0100_0000, 4'b0111, 2'b00);
    // illegal opcode traps after DECODE and stays there
    addVec(BAD,  1, S_F, C_FETCH, 4'b0000, 2'b00);
    addVec(BAD,  1, S_D, C_NONE,  4'b0000, 2'b00);
    addVec(BAD,  1, S_T, C_TRAP,  4'b0000, 2'b00);
    addVec(R,    1, S_T, C_TRAP,  4'b0000, 2'b00);
    addVec(R,    0, S_T, C_TRAP,  4'b0000, 2'b00);

    // reset state
    rst = 1'b1;
    applyStimulus(R, 1'b0);
    checkOutput("reset.state", 32'(state), 32'(S_F));
    checkOutput("reset.ctrl",  32'(ctrl_act), 32'(C_FWAIT));
    checkOutput("reset.aluop", 32'(aluop), 32'd0);
    resetDut();

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].opcode, vecs[i].mem_ready);
      checkOutput($sformatf("vec%0d.state", i),    32'(state),    32'(vecs[i].state));
      checkOutput($sformatf("vec%0d.ctrl", i),     32'(ctrl_act), 32'(vecs[i].ctrl));
      checkOutput($sformatf("vec%0d.aluop", i),    32'(aluop),    32'(vecs[i].aluop));
      checkOutput($sformatf("vec%0d.memtoreg", i), 32'(memtoreg), 32'(vecs[i].memtoreg));
      @(negedge clk);
    end

    // FETCH timeout: 14 idle cycles survive, the 15th traps
    resetDut();
    stepIdle(R, 1'b0, 14);
    applyStimulus(R, 1'b0);
    checkOutput("fetch_to.pre_state", 32'(state), 32'(S_F));
    @(negedge clk);
    #1;
    checkOutput("fetch_to.state", 32'(state), 32'(S_T));
    checkOutput("fetch_to.err",   32'(err),   32'd1);
    stepIdle(R, 1'b1, 3);
    #1;
    checkOutput("fetch_to.err_held", 32'(ctrl_act), 32'(C_TRAP));

    // mem_ready arriving on the timeout cycle completes the fetch normally
    resetDut();
    stepIdle(R, 1'b0, 14);
    applyStimulus(R, 1'b1);
    checkOutput("fetch_edge.irwrite", 32'(irwrite), 32'd1);
    @(negedge clk);
    #1;
    checkOutput("fetch_edge.state", 32'(state), 32'(S_D));
    checkOutput("fetch_edge.err",   32'(err),   32'd0);

    // MEM timeout on a store
    resetDut();
    stepIdle(ST, 1'b1, 3);
    stepIdle(ST, 1'b0, 14);
    applyStimulus(ST, 1'b0);
    checkOutput("mem_to.pre_state", 32'(state), 32'(S_M));
    @(negedge clk);
    #1;
    checkOutput("mem_to.state", 32'(state), 32'(S_T));
    checkOutput("mem_to.ctrl",  32'(ctrl_act), 32'(C_TRAP));

    // asynchronous reset in the middle of a pending store
    resetDut();
    stepIdle(ST, 1'b1, 3);
    applyStimulus(ST, 1'b0);
    checkOutput("rst_mem.pre_memwrite", 32'(memwrite), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_mem.memwrite", 32'(memwrite), 32'd0);
    checkOutput("rst_mem.state",    32'(state),    32'(S_F));
    checkOutput("rst_mem.err",      32'(err),      32'd0);
    @(negedge clk);
    rst = 1'b0;

`ifdef UC_MC_PERF_EN
    // three back-to-back R-type instructions
    resetDut();
    for (int n = 0; n < 3; n++) begin
      stepIdle(R, 1'b1, 4);
    end
    #1;
    checkOutput("perf.instr_cnt", instr_cnt, 32'd3);
    checkOutput("perf.cycle_cnt", cycle_cnt, 32'd12);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uc_mc.md
UC_MC -- requirements
Module: uc_mc

Interface
REQ-001 Parameter ALUOP_W, default 4, width of the aluop output (minimum 4).
REQ-002 Parameter TIMEOUT, default 15, maximum cycles to wait for mem_ready (minimum 1).
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 opcode  in  7  instruction opcode from memory, valid when mem_ready=1 in FETCH.
REQ-007 mem_ready  in  1  memory access complete this cycle.
REQ-008 mem_req  out  1  memory request, high in FETCH and MEM.
REQ-009 irwrite, pcwrite  out  1 each  latch instruction / advance PC.
REQ-010 regwrite, luisrc, alusrc, memwrite, memread, jumppc, jumpcontrol, bne  out  1 each  datapath controls.
REQ-011 aluop  out  ALUOP_W  ALU operation code.
REQ-012 memtoreg  out  2  writeback select: 00 ALU, 01 memory, 10 PC+4.
REQ-013 state  out  3  current FSM state; err  out  1  sticky trap flag.

Function
REQ-014 FSM states: FETCH, DECODE, EXEC, MEM, WB, TRAP.
REQ-015 FETCH: mem_req=1, memread=1; on a cycle with mem_ready=1: irwrite=1, pcwrite=1, op_q<=opcode, next DECODE.
REQ-016 DECODE: always goes to EXEC, except an opcode outside the legal set goes to TRAP.
REQ-017 Legal opcodes: 0110011 R, 0010011 I-ALU, 0000011 load, 0100011 store, 1100011 branch, 1101111 jal, 1100111 jalr, 0110111 lui, 0000000 nop.
REQ-018 Nop executes as addi x0,x0,0: regwrite=1, alusrc=1, aluop=I-ALU, with no other side effect.
REQ-019 EXEC next state:
  - load/store go to MEM;
  - branch goes to FETCH with bne=1 and jumpcontrol=1;
  - jal/jalr go to WB with jumppc=1;
  - all others go to WB.
REQ-020 MEM: mem_req=1; memread=1 for load, memwrite=1 for store; held until mem_ready=1.
REQ-021 MEM exit on mem_ready: load goes to WB, store goes to FETCH.
REQ-022 WB: regwrite=1 for one cycle, then FETCH.
REQ-023 WB memtoreg: 01 for load, 10 for jal/jalr, 00 otherwise.
REQ-024 Latency with mem_ready tied high: R/I/lui/nop 4 cycles, load 5, store 4, branch 3, jal/jalr 4.
REQ-025 aluop, luisrc and alusrc are Moore outputs decoded from op_q, valid in EXEC, MEM and WB.
REQ-026 aluop per opcode class:
  - R 0110, I-ALU/nop 0111;
  - load/store/jal/jalr 0000;
  - branch 0001;
  - lui 0010, with luisrc=1.
  Values are zero-extended to ALUOP_W.
REQ-027 All control outputs not asserted by the current state SHALL be 0.
REQ-028 Wait counter: cleared on entry to FETCH or MEM; increments each cycle mem_ready=0.
REQ-029 When the wait counter reaches TIMEOUT with mem_ready=0, the FSM goes to TRAP; if mem_ready=1 on that same cycle, the access completes normally.
REQ-030 TRAP: err=1, all other outputs 0; the FSM stays in TRAP until rst.

Reset
REQ-031 rst=1 immediately forces state=FETCH, op_q=0000000, wait counter=0, err=0; all control outputs reflect FETCH (mem_req=1, memread=1).
REQ-032 Reset asserted mid-instruction, including in MEM with a store pending, aborts the instruction; memwrite drops to 0 asynchronously.

Configuration
REQ-033 Macro UC_MC_PERF_EN defined: adds outputs cycle_cnt (32) and instr_cnt (32).
  - cycle_cnt increments every cycle outside reset.
  - instr_cnt increments on each transition to FETCH from WB, EXEC or MEM.
  - Both wrap modulo 2^32 and reset to 0.
REQ-034 Macro UC_MC_PERF_EN undefined: those ports and counters do not exist.

Structure
REQ-035 Shared package uc_pkg holds:
  - the opcode localparams;
  - the state encoding (FETCH=0 ... TRAP=5);
  - the aluop class codes;
  - the memtoreg codes.
REQ-036 Sub-module uc_mc_decode: combinational mapping op_q to aluop/luisrc/alusrc/memtoreg/class, instantiated once.

Verification
REQ-037 rst pulse mid-MEM of a store → state=0, memwrite=0 during reset, err=0.
REQ-038 opcode=0110011, mem_ready=1 → states FETCH,DECODE,EXEC,WB; regwrite=1 only in WB; aluop=0110 in EXEC; memtoreg=00.
REQ-039 opcode=0000011, mem_ready low 3 cycles in MEM → 8 cycles total; memread=1 in MEM; WB memtoreg=01.
REQ-040 opcode=1100011 → 3 cycles; bne=1 and jumpcontrol=1 in EXEC only; regwrite never 1.
REQ-041 opcode=1111111 → DECODE then TRAP, err=1 held; also mem_ready=0 for 15 cycles in FETCH → TRAP.
REQ-042 UC_MC_PERF_EN defined: 3 R-type instructions with mem_ready=1 → instr_cnt=3, cycle_cnt=12.
